// File: rtl/spi_sram_responder.sv
// SPI mode-0 slave decoding the 23LC512 command set onto an async-read RAM port.
// Latency: MOSI taken one clk after SCLK rises; write strobe one clk after the 8th rise.
// Backpressure: none; the SPI master paces everything, and CS high aborts at once.
module spi_sram_responder #(
  parameter int PAGE_BITS = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_cs_n,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic        mem_wr_en,
  output logic [7:0]  mem_wdata,
  output logic        cmd_err
);

  typedef enum logic [3:0] {
    IDLE, CMD, ADDR_HI, ADDR_LO, RD_DATA, WR_DATA, MODE_RD, MODE_WR, IGNORE
  } state_t;

  state_t      state, state_nx;
  logic        sclk_q;
  logic [2:0]  bit_idx;
  logic [6:0]  shreg;
  logic        is_write;
  logic [7:0]  addr_hi;
  logic [1:0]  mode;
  // Set once the single transfer allowed in byte mode (or a WRMR byte) is done.
  logic        frozen;

  logic        rise;
  logic        byte_done;
  logic [7:0]  byte_val;
  logic [7:0]  mode_byte;
  logic        load_addr;
  logic        rd_adv;
  logic        wr_fire;
  logic        err_fire;
  logic        mode_ld;
  logic        miso_bit;

  assign rise      = spi_sclk & ~sclk_q;
  // A byte only completes while selected, so a simultaneous CS release wins.
  assign byte_done = rise & ~spi_cs_n & (bit_idx == 3'd7);
  assign byte_val  = {shreg, spi_mosi};
  assign mode_byte = {mode, 6'b0};

  function automatic logic [15:0] next_addr(input logic [15:0] a, input logic [1:0] m);
    logic [15:0] inc;
    logic [15:0] res;
    inc = a + 16'd1;
    res = a;
    if (m == 2'b01) res = inc;
    else if (m == 2'b10) res = {a[15:PAGE_BITS], inc[PAGE_BITS-1:0]};
    return res;
  endfunction

  // Next-state decode plus the single-cycle action strobes.
  always_comb begin
    state_nx  = state;
    load_addr = 1'b0;
    rd_adv    = 1'b0;
    wr_fire   = 1'b0;
    err_fire  = 1'b0;
    mode_ld   = 1'b0;
    if (spi_cs_n) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    state_nx = CMD;
        CMD: if (byte_done) begin
          case (byte_val)
            8'h03, 8'h02: state_nx = ADDR_HI;
            8'h05:        state_nx = MODE_RD;
            8'h01:        state_nx = MODE_WR;
            default: begin
              state_nx = IGNORE;
              err_fire = 1'b1;
            end
          endcase
        end
        ADDR_HI: if (byte_done) state_nx = ADDR_LO;
        ADDR_LO: if (byte_done) begin
          state_nx  = is_write ? WR_DATA : RD_DATA;
          load_addr = 1'b1;
        end
        RD_DATA: if (byte_done && !frozen) rd_adv = 1'b1;
        WR_DATA: if (byte_done && !frozen) wr_fire = 1'b1;
        MODE_WR: if (byte_done && !frozen && byte_val[7:6] != 2'b11) mode_ld = 1'b1;
        default: ;
      endcase
    end
  end

  // State register and SCLK edge-detect delay.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sclk_q <= 1'b0;
    end else begin
      state  <= state_nx;
      sclk_q <= spi_sclk;
    end
  end

  // Bit shifter, counter and per-transaction command context.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_idx  <= 3'd0;
      shreg    <= 7'd0;
      is_write <= 1'b0;
      addr_hi  <= 8'h00;
      frozen   <= 1'b0;
    end else begin
      if (spi_cs_n) begin
        bit_idx <= 3'd0;
      end else if (rise) begin
        bit_idx <= bit_idx + 3'd1;
        shreg   <= {shreg[5:0], spi_mosi};
      end
      if (state == CMD && byte_done) is_write <= (byte_val == 8'h02);
      if (state == ADDR_HI && byte_done) addr_hi <= byte_val;
      if (spi_cs_n || load_addr) frozen <= 1'b0;
      else if (byte_done && (state == MODE_WR ||
               ((state == RD_DATA || state == WR_DATA) && mode == 2'b00)))
        frozen <= 1'b1;
    end
  end

  // Memory port, mode register and error pulse. A write's address advances the
  // cycle after its strobe so mem_addr stays valid alongside mem_wr_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr  <= 16'h0000;
      mem_wr_en <= 1'b0;
      mem_wdata <= 8'h00;
      mode      <= 2'b01;
      cmd_err   <= 1'b0;
    end else begin
      mem_wr_en <= wr_fire;
      cmd_err   <= err_fire;
      if (wr_fire) mem_wdata <= byte_val;
      if (mode_ld) mode <= byte_val[7:6];
      if (load_addr) mem_addr <= {addr_hi, byte_val};
      else if (rd_adv || mem_wr_en) mem_addr <= next_addr(mem_addr, mode);
    end
  end

  // MISO source: RAM bit or mode register bit, forced low when not driving.
  always_comb begin
    miso_bit = 1'b0;
    case (state)
      RD_DATA: if (!frozen) miso_bit = mem_rdata[3'd7 - bit_idx];
      MODE_RD: miso_bit = mode_byte[3'd7 - bit_idx];
      default: ;
    endcase
  end

  assign spi_miso_oe = ~spi_cs_n & (state == RD_DATA || state == MODE_RD);
  assign spi_miso    = miso_bit & spi_miso_oe;

endmodule
